// File: rtl/tomasulo_pkg.sv
// Shared opcode, field and sizing definitions for the Tomasulo issue front end.
// Also holds the small opcode-class helpers used by the issue logic.
package tomasulo_pkg;

    localparam int IQ_DEPTH  = 4;
    localparam int ROB_DEPTH = 8;
    localparam int NREG      = 16;
    localparam int ROB_W     = $clog2(ROB_DEPTH);
    localparam int INSTR_W   = 16;

    localparam int FUNC_MSB = 15;
    localparam int FUNC_LSB = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 8;
    localparam int RS1_MSB  = 7;
    localparam int RS1_LSB  = 4;
    localparam int RS2_MSB  = 3;
    localparam int RS2_LSB  = 0;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;
    localparam logic [3:0] FUNC_LD  = 4'b0100;
    localparam logic [3:0] FUNC_ST  = 4'b0101;
    localparam logic [3:0] FUNC_BEQ = 4'b0110;
    localparam logic [3:0] FUNC_BNE = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STALL
    } issue_state_t;

    function automatic logic is_mul_class(input logic [3:0] f);
        return f[3:1] == FUNC_MUL[3:1];
    endfunction

    // Stores and branches still take a ROB slot but never produce a register value.
    function automatic logic is_no_rd(input logic [3:0] f);
        return (f == FUNC_ST) || (f[3:1] == FUNC_BEQ[3:1]);
    endfunction

    function automatic logic is_illegal(input logic [3:0] f);
        return f[3];
    endfunction

endpackage

// File: rtl/issue_iq_fifo.sv
// Instruction queue for the issue stage: power-of-two FIFO with wrapping pointers.
// A push into a full queue is honoured when a pop happens in the same cycle.
module issue_iq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      used;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (used == (PW+1)'(DEPTH));
    assign empty   = (used == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   used <= used + (PW+1)'(1);
                2'b01:   used <= used - (PW+1)'(1);
                default: used <= used;
            endcase
        end
    end

    // Storage carries no reset; an entry is only read after it has been written.
    always_ff @(posedge clk1) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/issue_unit.sv
// Issue stage of the Tomasulo core: queues instructions, allocates ROB slots and renames sources.
// Define ISSUE_CDB_BYPASS_EN to forward a same-cycle CDB broadcast into the source lookup.
import tomasulo_pkg::*;

module issue_unit (
    input  logic        clk1,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr_in,
    output logic        instr_ready,
    input  logic        add_full,
    input  logic        mul_full,
    input  logic        rob_commit,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_rob,
    output logic        count,
    output logic [3:0]  func,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic        rs1_b,
    output logic        rs2_b,
    output logic [3:0]  rd,
    output logic [2:0]  rob_ind,
    output logic        illegal
);

    issue_state_t     state_q, state_d;
    logic [15:0]      iq_head;
    logic             iq_full, iq_empty, iq_push, iq_pop;
    logic [3:0]       head_func, head_rd, head_rs1, head_rs2;
    logic [NREG-1:0]  busy_q;
    logic [ROB_W-1:0] tag_q [NREG];
    logic [ROB_W-1:0] rob_tail_q;
    logic [ROB_W:0]   rob_used_q;
    logic             do_issue, do_drop, commit_eff;
    logic             rs_blocked, rob_blocked, hazard;
    logic             cdb_hit1, cdb_hit2, src1_ready, src2_ready;

    issue_iq_fifo #(.DEPTH(IQ_DEPTH), .WIDTH(INSTR_W)) u_iq (
        .clk1  (clk1),
        .rst   (rst),
        .push  (iq_push),
        .pop   (iq_pop),
        .din   (instr_in),
        .head  (iq_head),
        .full  (iq_full),
        .empty (iq_empty)
    );

    assign head_func   = iq_head[FUNC_MSB:FUNC_LSB];
    assign head_rd     = iq_head[RD_MSB:RD_LSB];
    assign head_rs1    = iq_head[RS1_MSB:RS1_LSB];
    assign head_rs2    = iq_head[RS2_MSB:RS2_LSB];
    assign iq_pop      = do_issue || do_drop;
    assign instr_ready = !iq_full || iq_pop;
    assign iq_push     = instr_valid && instr_ready;
    assign count       = (state_q == ST_ISSUE);

    // A commit in the same cycle frees the slot the head is waiting for.
    assign commit_eff  = rob_commit && (rob_used_q != '0);
    assign rob_blocked = (rob_used_q == (ROB_W+1)'(ROB_DEPTH)) && !rob_commit;
    assign rs_blocked  = is_mul_class(head_func) ? mul_full : add_full;
    assign cdb_hit1    = cdb_valid && busy_q[head_rs1] && (tag_q[head_rs1] == cdb_rob);
    assign cdb_hit2    = cdb_valid && busy_q[head_rs2] && (tag_q[head_rs2] == cdb_rob);

`ifdef ISSUE_CDB_BYPASS_EN
    assign src1_ready = !busy_q[head_rs1] || cdb_hit1;
    assign src2_ready = !busy_q[head_rs2] || cdb_hit2;
    assign hazard     = 1'b0;
`else
    assign src1_ready = !busy_q[head_rs1];
    assign src2_ready = !busy_q[head_rs2];
    assign hazard     = cdb_hit1 || cdb_hit2;
`endif

    always_comb begin
        state_d  = ST_IDLE;
        do_issue = 1'b0;
        do_drop  = 1'b0;
        if (!iq_empty) begin
            if (is_illegal(head_func)) begin
                do_drop = 1'b1;
            end else if (rs_blocked || rob_blocked || hazard) begin
                state_d = ST_STALL;
            end else begin
                do_issue = 1'b1;
                state_d  = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Data outputs hold their last issued values while count is low.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
            func    <= '0;
            rd      <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rs1_b   <= 1'b0;
            rs2_b   <= 1'b0;
            rob_ind <= '0;
        end else begin
            illegal <= do_drop;
            if (do_issue) begin
                func    <= head_func;
                rd      <= head_rd;
                rs1     <= src1_ready ? head_rs1 : {1'b0, tag_q[head_rs1]};
                rs2     <= src2_ready ? head_rs2 : {1'b0, tag_q[head_rs2]};
                rs1_b   <= src1_ready;
                rs2_b   <= src2_ready;
                rob_ind <= rob_tail_q;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            rob_tail_q <= '0;
            rob_used_q <= '0;
        end else begin
            if (do_issue) rob_tail_q <= rob_tail_q + ROB_W'(1);
            if (do_issue && !commit_eff)      rob_used_q <= rob_used_q + (ROB_W+1)'(1);
            else if (!do_issue && commit_eff) rob_used_q <= rob_used_q - (ROB_W+1)'(1);
        end
    end

    // The issue write comes after the CDB clear so it wins on the same register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) tag_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (cdb_valid && busy_q[r] && (tag_q[r] == cdb_rob)) busy_q[r] <= 1'b0;
            end
            if (do_issue && !is_no_rd(head_func)) begin
                busy_q[head_rd] <= 1'b1;
                tag_q[head_rd]  <= rob_tail_q;
            end
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Randomized and directed checking of issue_unit against a queue/array reference model.
// Honours ISSUE_CDB_BYPASS_EN the same way the design does.
module tb_issue_unit;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr_in;
    logic        instr_ready;
    logic        add_full, mul_full, rob_commit, cdb_valid;
    logic [2:0]  cdb_rob;
    logic        count, rs1_b, rs2_b, illegal;
    logic [3:0]  func, rs1, rs2, rd;
    logic [2:0]  rob_ind;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_busy [16];
    logic [2:0]  m_tag [16];
    int          m_used, m_tail;
    logic        m_issue, m_drop, m_ready;
    logic        e_count, e_illegal, e_rs1b, e_rs2b;
    logic [3:0]  e_func, e_rd, e_rs1, e_rs2;
    logic [2:0]  e_rob;
    logic [3:0]  n_rs1, n_rs2;
    logic        n_rs1b, n_rs2b;

    issue_unit dut (
        .clk1        (clk1),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .instr_ready (instr_ready),
        .add_full    (add_full),
        .mul_full    (mul_full),
        .rob_commit  (rob_commit),
        .cdb_valid   (cdb_valid),
        .cdb_rob     (cdb_rob),
        .count       (count),
        .func        (func),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_b       (rs1_b),
        .rs2_b       (rs2_b),
        .rd          (rd),
        .rob_ind     (rob_ind),
        .illegal     (illegal)
    );

    always #5 clk1 = ~clk1;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int r = 0; r < 16; r++) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = 3'd0;
        end
        m_used = 0;
        m_tail = 0;
        e_count = 1'b0;
        e_illegal = 1'b0;
        e_func = 4'd0; e_rd = 4'd0; e_rs1 = 4'd0; e_rs2 = 4'd0;
        e_rs1b = 1'b0; e_rs2b = 1'b0; e_rob = 3'd0;
    endtask

    // Called at a negedge: drives one cycle, checks ready, advances the model, checks outputs.
    task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic af,
                                 input logic mf, input logic cm, input logic cv,
                                 input logic [2:0] cr);
        logic [15:0] h;
        logic [3:0]  f, d, s1, s2;
        logic        blocked, hit1, hit2, av1, av2;
        instr_valid = v;
        instr_in    = ins;
        add_full    = af;
        mul_full    = mf;
        rob_commit  = cm;
        cdb_valid   = cv;
        cdb_rob     = cr;
        #1;
        m_issue = 1'b0;
        m_drop  = 1'b0;
        h = 16'h0;
        if (m_q.size() > 0) begin
            h  = m_q[0];
            f  = h[15:12]; d = h[11:8]; s1 = h[7:4]; s2 = h[3:0];
            if (f >= 4'd8) begin
                m_drop = 1'b1;
            end else begin
                blocked = (f == 4'd2 || f == 4'd3) ? mf : af;
                if (m_used == 8 && !cm) blocked = 1'b1;
                hit1 = cv && m_busy[s1] && (m_tag[s1] == cr);
                hit2 = cv && m_busy[s2] && (m_tag[s2] == cr);
`ifdef ISSUE_CDB_BYPASS_EN
                av1 = !m_busy[s1] || hit1;
                av2 = !m_busy[s2] || hit2;
`else
                if (hit1 || hit2) blocked = 1'b1;
                av1 = !m_busy[s1];
                av2 = !m_busy[s2];
`endif
                if (!blocked) begin
                    m_issue = 1'b1;
                    n_rs1b = av1;
                    n_rs2b = av2;
                    n_rs1  = av1 ? s1 : {1'b0, m_tag[s1]};
                    n_rs2  = av2 ? s2 : {1'b0, m_tag[s2]};
                end
            end
        end
        m_ready = (m_q.size() < 4) || m_issue || m_drop;
        checkOutput("instr_ready", 16'(instr_ready), 16'(m_ready));
        @(posedge clk1);
        if (cv) begin
            for (int r = 0; r < 16; r++)
                if (m_busy[r] && m_tag[r] == cr) m_busy[r] = 1'b0;
        end
        if (m_issue) begin
            f = h[15:12]; d = h[11:8];
            e_func = f; e_rd = d; e_rs1 = n_rs1; e_rs2 = n_rs2;
            e_rs1b = n_rs1b; e_rs2b = n_rs2b; e_rob = 3'(m_tail);
            if (!(f == 4'd5 || f == 4'd6 || f == 4'd7)) begin
                m_busy[d] = 1'b1;
                m_tag[d]  = 3'(m_tail);
            end
            m_tail = (m_tail + 1) % 8;
        end
        m_used = m_used + (m_issue ? 1 : 0) - ((cm && m_used > 0) ? 1 : 0);
        if (m_issue || m_drop) void'(m_q.pop_front());
        if (v && m_ready) m_q.push_back(ins);
        e_count   = m_issue;
        e_illegal = m_drop;
        @(negedge clk1);
        checkOutput("count", 16'(count), 16'(e_count));
        checkOutput("illegal", 16'(illegal), 16'(e_illegal));
        if (e_count) begin
            checkOutput("func", 16'(func), 16'(e_func));
            checkOutput("rd", 16'(rd), 16'(e_rd));
            checkOutput("rs1", 16'(rs1), 16'(e_rs1));
            checkOutput("rs2", 16'(rs2), 16'(e_rs2));
            checkOutput("rs1_b", 16'(rs1_b), 16'(e_rs1b));
            checkOutput("rs2_b", 16'(rs2_b), 16'(e_rs2b));
            checkOutput("rob_ind", 16'(rob_ind), 16'(e_rob));
        end
    endtask

    task automatic idle(input logic cm);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, cm, 1'b0, 3'd0);
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0; instr_in = 16'h0; add_full = 1'b0; mul_full = 1'b0;
        rob_commit = 1'b0; cdb_valid = 1'b0; cdb_rob = 3'd0;
        model_reset();
        @(negedge clk1);
        @(negedge clk1);
        checkOutput("rst_count", 16'(count), 16'h0);
        checkOutput("rst_illegal", 16'(illegal), 16'h0);
        checkOutput("rst_ready", 16'(instr_ready), 16'h1);
        checkOutput("rst_func", 16'(func), 16'h0);
        checkOutput("rst_rd", 16'(rd), 16'h0);
        checkOutput("rst_rs1", 16'(rs1), 16'h0);
        checkOutput("rst_rs2", 16'(rs2), 16'h0);
        checkOutput("rst_rs1_b", 16'(rs1_b), 16'h0);
        checkOutput("rst_rob_ind", 16'(rob_ind), 16'h0);
        rst = 1'b0;

        // add r3,r1,r2 then mul r4,r3,r3
        applyStimulus(1'b1, 16'h0312, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 16'h2433, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("t1_count", 16'(count), 16'h1);
        checkOutput("t1_rob", 16'(rob_ind), 16'h0);
        checkOutput("t1_rs1", 16'(rs1), 16'h1);
        checkOutput("t1_rs2", 16'(rs2), 16'h2);
        checkOutput("t1_rs1_b", 16'(rs1_b), 16'h1);
        idle(1'b0);
        checkOutput("t2_rob", 16'(rob_ind), 16'h1);
        checkOutput("t2_rs1_b", 16'(rs1_b), 16'h0);
        checkOutput("t2_rs1", 16'(rs1), 16'h0);

        // mul held back by mul_full
        applyStimulus(1'b1, 16'h2512, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput("t3_stall", 16'(count), 16'h0);
        idle(1'b0);
        checkOutput("t3_go", 16'(count), 16'h1);

        // fill the ROB; the ninth waits for a commit and wraps to slot 0
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, {4'h0, 4'(7 + i), 4'h1, 4'h2}, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("t4_full", 16'(count), 16'h0);
        idle(1'b1);
        checkOutput("t4_count", 16'(count), 16'h1);
        checkOutput("t4_wrap", 16'(rob_ind), 16'h0);

        // CDB tag 0 broadcast while sub r6,r3,r0 looks up r3
        idle(1'b1); idle(1'b1); idle(1'b1);
        applyStimulus(1'b1, 16'h1630, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
`ifdef ISSUE_CDB_BYPASS_EN
        checkOutput("t5_count", 16'(count), 16'h1);
`else
        checkOutput("t5_count", 16'(count), 16'h0);
`endif
        idle(1'b0);

        // illegal func, then reset in the middle of a stall
        applyStimulus(1'b1, 16'hA123, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(1'b0);
        checkOutput("t6_illegal", 16'(illegal), 16'h1);
        checkOutput("t6_rob", 16'(rob_ind), 16'(e_rob));
        idle(1'b0);
        applyStimulus(1'b1, 16'h0312, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_count", 16'(count), 16'h0);
        checkOutput("t6_rst_ready", 16'(instr_ready), 16'h1);
        checkOutput("t6_rst_func", 16'(func), 16'h0);
        checkOutput("t6_rst_rd", 16'(rd), 16'h0);
        instr_valid = 1'b0; add_full = 1'b0;
        model_reset();
        @(negedge clk1);
        rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            int          k;
            logic [3:0]  f;
            logic [15:0] ins;
            k   = $urandom_range(0, 9);
            f   = (k == 9) ? 4'(8 + $urandom_range(0, 7)) : 4'(k % 8);
            ins = {f, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            applyStimulus(($urandom_range(0, 9) < 7), ins,
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                          (m_used > 0) && ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)));
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
